// File: rtl/contador_pkg.sv
// contador_pkg: shared state encoding and default width for counter blocks
package contador_pkg;
    localparam int LARGURA_PADRAO = 4;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } estado_t;
endpackage

// File: rtl/gerador_tick.sv
// gerador_tick: prescaler that pulses tick once every DIV enabled cycles
module gerador_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic habilita,
    input  logic limpa,
    output logic tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    logic [W-1:0] r_pre;
    assign tick = habilita && (r_pre == W'(DIV - 1));
    // prescaler holds when disabled, wraps to 0 on tick
    always_ff @(posedge clk) begin
        if (reset || limpa)
            r_pre <= '0;
        else if (habilita)
            r_pre <= tick ? '0 : r_pre + 1'b1;
    end
endmodule

// File: rtl/controlador_contador.sv
// controlador_contador: up/down run counter with pause, abort and one-cycle done pulse
module controlador_contador
    import contador_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO,
    parameter int DIV     = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               parar,
    input  logic               pausa,
    input  logic               modo,
    input  logic [LARGURA-1:0] limite,
    output logic [LARGURA-1:0] count,
    output logic               ocupado,
    output logic               pausado,
    output logic               fim
);
    estado_t            r_estado;
    logic               r_modo;
    logic [LARGURA-1:0] r_limite;
    logic [LARGURA-1:0] r_count;
    logic               w_tick;
    logic               w_habilita;
    logic               w_limpa;
    logic [LARGURA-1:0] w_terminal;

    // prescaler only advances on a RUN edge that is not overridden by parar/pausa
    assign w_habilita = (r_estado == RUN) && !parar && !pausa;
    assign w_limpa    = (r_estado == IDLE) || (r_estado == DONE);
    assign w_terminal = r_modo ? '0 : r_limite;

    gerador_tick #(.DIV(DIV)) u_tick (
        .clk      (clk),
        .reset    (reset),
        .habilita (w_habilita),
        .limpa    (w_limpa),
        .tick     (w_tick)
    );

    // state machine and count datapath; priority reset > parar > pausa > tick
    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado <= IDLE;
            r_count  <= '0;
            r_modo   <= 1'b0;
            r_limite <= '0;
        end else begin
            case (r_estado)
                IDLE, DONE: begin
                    if (start) begin
                        r_modo   <= modo;
                        r_limite <= limite;
                        r_count  <= modo ? limite : '0;
                        r_estado <= RUN;
                    end else begin
                        r_estado <= IDLE;
                    end
                end
                RUN: begin
                    if (parar)
                        r_estado <= IDLE;
                    else if (pausa)
                        r_estado <= PAUSE;
                    else if (w_tick) begin
                        if (r_count == w_terminal)
                            r_estado <= DONE;
                        else
                            r_count <= r_modo ? r_count - 1'b1 : r_count + 1'b1;
                    end
                end
                PAUSE: begin
                    if (parar)
                        r_estado <= IDLE;
                    else if (!pausa)
                        r_estado <= RUN;
                end
                default: r_estado <= IDLE;
            endcase
        end
    end

    assign count   = r_count;
    assign ocupado = (r_estado == RUN) || (r_estado == PAUSE);
    assign pausado = (r_estado == PAUSE);
    assign fim     = (r_estado == DONE);
endmodule

// File: tb/tb_controlador_contador.sv
// tb_controlador_contador: table-driven scoreboard bench for DIV=1 and DIV=2 instances
module tb_controlador_contador;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       parar = 1'b0;
    logic       pausa = 1'b0;
    logic       modo = 1'b0;
    logic [3:0] limite = 4'd0;
    logic [3:0] count1, count2;
    logic       ocupado1, pausado1, fim1;
    logic       ocupado2, pausado2, fim2;

    typedef struct {
        logic       sel;
        logic       rst, st, pa, pu, mo;
        logic [3:0] lim;
        logic [3:0] cnt;
        logic       ocu, pau, fim;
    } vec_t;

    typedef struct {
        logic       sel;
        logic [3:0] cnt;
        logic       ocu, pau, fim;
    } exp_t;

    vec_t tab[$];
    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_step = 0;

    always #5 clk = ~clk;

    controlador_contador #(.LARGURA(4), .DIV(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .parar(parar), .pausa(pausa),
        .modo(modo), .limite(limite), .count(count1), .ocupado(ocupado1),
        .pausado(pausado1), .fim(fim1)
    );

    controlador_contador #(.LARGURA(4), .DIV(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .parar(parar), .pausa(pausa),
        .modo(modo), .limite(limite), .count(count2), .ocupado(ocupado2),
        .pausado(pausado2), .fim(fim2)
    );

    task automatic chk(input string name, input int step, input logic [3:0] act, input logic [3:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d required %0d", name, step, act, req);
        end
    endtask

    task automatic add(input logic sel, rst, st, pa, pu, mo, input logic [3:0] lim,
                       input logic [3:0] cnt, input logic ocu, pau, f);
        vec_t v;
        v.sel = sel; v.rst = rst; v.st = st; v.pa = pa; v.pu = pu; v.mo = mo;
        v.lim = lim; v.cnt = cnt; v.ocu = ocu; v.pau = pau; v.fim = f;
        tab.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        @(negedge clk);
        reset = v.rst; start = v.st; parar = v.pa; pausa = v.pu; modo = v.mo; limite = v.lim;
        e.sel = v.sel; e.cnt = v.cnt; e.ocu = v.ocu; e.pau = v.pau; e.fim = v.fim;
        sb.push_back(e);
    endtask

    // checker: pops the expectation pushed before each edge and compares after it
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_step++;
            chk(e.sel ? "count_div2" : "count_div1", n_step, e.sel ? count2 : count1, e.cnt);
            chk(e.sel ? "ocupado_div2" : "ocupado_div1", n_step, {3'b0, e.sel ? ocupado2 : ocupado1}, {3'b0, e.ocu});
            chk(e.sel ? "pausado_div2" : "pausado_div1", n_step, {3'b0, e.sel ? pausado2 : pausado1}, {3'b0, e.pau});
            chk(e.sel ? "fim_div2" : "fim_div1", n_step, {3'b0, e.sel ? fim2 : fim1}, {3'b0, e.fim});
        end
    end

    initial begin
        // DIV=1: reset, start ignored under reset, up 0..3 with limite/modo changed mid-run
        add(0,1,0,0,0,0,0, 0,0,0,0);
        add(0,1,1,0,0,0,3, 0,0,0,0);
        add(0,0,0,0,0,0,3, 0,0,0,0);
        add(0,0,1,0,0,0,3, 0,1,0,0);
        add(0,0,0,0,0,0,9, 1,1,0,0);
        add(0,0,0,0,0,1,9, 2,1,0,0);
        add(0,0,0,0,0,0,9, 3,1,0,0);
        add(0,0,0,0,0,0,9, 3,0,0,1);
        add(0,0,0,0,0,0,9, 3,0,0,0);
        add(0,0,0,1,1,0,9, 3,0,0,0);
        // parar+pausa together in RUN abort to IDLE holding count
        add(0,0,1,0,0,0,7, 0,1,0,0);
        add(0,0,0,0,0,0,7, 1,1,0,0);
        add(0,0,0,0,0,0,7, 2,1,0,0);
        add(0,0,0,1,1,0,7, 2,0,0,0);
        add(0,0,0,0,0,0,7, 2,0,0,0);
        // limite=0 finishes on first tick; start held restarts from DONE (down from 3)
        add(0,0,1,0,0,0,0, 0,1,0,0);
        add(0,0,1,0,0,0,0, 0,0,0,1);
        add(0,0,1,0,0,1,3, 3,1,0,0);
        add(0,0,0,0,0,1,3, 2,1,0,0);
        add(0,1,0,0,0,1,3, 0,0,0,0);
        // reset on the edge that would enter DONE suppresses fim
        add(0,0,1,0,0,0,0, 0,1,0,0);
        add(0,1,0,0,0,0,0, 0,0,0,0);
        // reset while in DONE, with start on the same edge ignored
        add(0,0,1,0,0,0,1, 0,1,0,0);
        add(0,0,0,0,0,0,1, 1,1,0,0);
        add(0,0,0,0,0,0,1, 1,0,0,1);
        add(0,1,1,0,0,0,1, 0,0,0,0);
        // start ignored in RUN
        add(0,0,1,0,0,0,2, 0,1,0,0);
        add(0,0,1,0,0,1,9, 1,1,0,0);
        add(0,0,0,0,0,0,2, 2,1,0,0);
        add(0,0,0,0,0,0,2, 2,0,0,1);
        add(0,0,0,0,0,0,2, 2,0,0,0);
        // pause then abort from PAUSE
        add(0,0,1,0,0,0,3, 0,1,0,0);
        add(0,0,0,0,0,0,3, 1,1,0,0);
        add(0,0,0,0,1,0,3, 1,1,1,0);
        add(0,0,0,0,1,0,3, 1,1,1,0);
        add(0,0,0,1,1,0,3, 1,0,0,0);
        // DIV=2: down from 5, one step every 2 cycles, fim 2 cycles after reaching 0
        add(1,1,0,0,0,0,0, 0,0,0,0);
        add(1,0,1,0,0,1,5, 5,1,0,0);
        for (int k = 0; k < 11; k++)
            add(1,0,0,0,0,0,0, 4'(5 - (k + 1) / 2),1,0,0);
        add(1,0,0,0,0,0,0, 0,0,0,1);
        add(1,0,0,0,0,0,0, 0,0,0,0);
        foreach (tab[i]) drive(tab[i]);
        // DIV=2 hand sequence: pause 4 cycles at count=2 with prescaler mid-phase
        tab.delete();
        add(1,1,0,0,0,0,0, 0,0,0,0);
        add(1,0,1,0,0,0,4, 0,1,0,0);
        add(1,0,0,0,0,0,4, 0,1,0,0);
        add(1,0,0,0,0,0,4, 1,1,0,0);
        add(1,0,0,0,0,0,4, 1,1,0,0);
        add(1,0,0,0,0,0,4, 2,1,0,0);
        add(1,0,0,0,0,0,4, 2,1,0,0);
        for (int k = 0; k < 4; k++)
            add(1,0,0,0,1,0,4, 2,1,1,0);
        add(1,0,0,0,0,0,4, 2,1,0,0);
        add(1,0,0,0,0,0,4, 3,1,0,0);
        add(1,0,0,0,0,0,4, 3,1,0,0);
        add(1,0,0,0,0,0,4, 4,1,0,0);
        add(1,0,0,0,0,0,4, 4,1,0,0);
        add(1,0,0,0,0,0,4, 4,0,0,1);
        add(1,0,0,0,0,0,4, 4,0,0,0);
        foreach (tab[i]) drive(tab[i]);
        @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
